// File: rtl/bcd_avg_formatter.sv
// Block averager for ring-oscillator counts: averages 2^AVG_LOG2 samples, saturates at 9999,
// and converts to 4-digit packed BCD with a one-iteration-per-cycle double-dabble.
module bcd_avg_formatter #(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic        fpga_clk1,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        overflow
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = SAMPLE_W + AVG_LOG2;
  localparam int unsigned CNT_W    = AVG_LOG2 + 1;
  localparam int unsigned LAST_IDX = (1 << AVG_LOG2) - 1;
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned ITERS    = 14;
  localparam int unsigned ITER_W   = 4;
  localparam int unsigned MAX_DEC  = 9999;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [ITER_W-1:0]  iter;
  logic               pend_ovf;

  logic [ACC_W-1:0]    sum_c;
  logic [SAMPLE_W-1:0] avg_c;
  logic                sat_c;
  logic [BIN_W-1:0]    load_c;
  logic [BCD_W-1:0]    adj_c;
  logic                last_c;

  // Average of the completed block, its saturated load value, and the add-3 nibble correction
  always_comb begin
    sum_c  = acc + ACC_W'(sample);
    avg_c  = SAMPLE_W'(sum_c >> AVG_LOG2);
    sat_c  = avg_c > SAMPLE_W'(MAX_DEC);
    load_c = sat_c ? BIN_W'(MAX_DEC) : avg_c[BIN_W-1:0];
    last_c = (cnt == CNT_W'(LAST_IDX));
    adj_c  = bcd_sr;
    for (int n = 0; n < 4; n++) begin
      if (bcd_sr[4*n +: 4] >= 4'd5) adj_c[4*n +: 4] = bcd_sr[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge fpga_clk1) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      iter      <= '0;
      pend_ovf  <= 1'b0;
      busy      <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        ACCUM: begin
          if (sample_valid) begin
            if (last_c) begin
              acc      <= '0;
              cnt      <= '0;
              bin_sr   <= load_c;
              bcd_sr   <= '0;
              iter     <= '0;
              pend_ovf <= sat_c;
              busy     <= 1'b1;
              state    <= CONVERT;
            end else begin
              acc <= sum_c;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        CONVERT: begin
          // Correct first, then shift the next binary MSB into the BCD register
          bcd_sr <= {adj_c[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
          iter   <= iter + ITER_W'(1);
          if (iter == ITER_W'(ITERS - 1)) state <= DONE;
        end
        DONE: begin
          bcd_out   <= bcd_sr;
          overflow  <= pend_ovf;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
